// File: rtl/multicycle_control_if.sv
// Shared memory-port handshake between the multicycle controller and the memory arbiter.
// The controller (master) raises mem_req/mem_we; the memory side answers with mem_ack.
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        output mem_ack
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the soft core: fetch/decode/execute/memory/write-back sequencing,
// datapath enables, memory-port handshake and retired-instruction counting.
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [5:0]            opcode,
    multicycle_control_if.master  mem,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  pc_write_cond,
    output logic [1:0]            pc_src,
    output logic [1:0]            alu_op,
    output logic                  alu_src,
    output logic                  reg_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  retired,
    output logic                  illegal,
    output logic [CNT_W-1:0]      instr_count,
    output logic [2:0]            state
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] MEM    = 3'd4;
    localparam logic [2:0] WB     = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic             end_instr;
    logic             legal;

    assign legal = (opcode == OP_RTYPE) || (opcode == OP_ADDI) || (opcode == OP_LW) ||
                   (opcode == OP_SW) || (opcode == OP_BEQ) || (opcode == OP_J);

    always_comb begin
        state_d       = state_q;
        end_instr     = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        alu_op        = 2'b00;
        alu_src       = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        retired       = 1'b0;
        illegal       = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = 2'b00;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                if (opcode == OP_J) begin
                    pc_write  = 1'b1;
                    pc_src    = 2'b10;
                    retired   = 1'b1;
                    end_instr = 1'b1;
                end else if (!legal) begin
                    illegal   = 1'b1;
                    end_instr = 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (opcode == OP_RTYPE) begin
                    alu_op  = 2'b10;
                    state_d = WB;
                end else if (opcode == OP_BEQ) begin
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_src        = 2'b01;
                    retired       = 1'b1;
                    end_instr     = 1'b1;
                end else begin
                    // addi, lw, sw all compute base + sign-extended immediate
                    alu_op  = 2'b00;
                    alu_src = 1'b1;
                    state_d = (opcode == OP_ADDI) ? WB : MEM;
                end
            end
            MEM: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = (opcode == OP_SW);
                if (mem.mem_ack) begin
                    if (opcode == OP_SW) begin
                        retired   = 1'b1;
                        end_instr = 1'b1;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode == OP_RTYPE);
                mem_to_reg = (opcode == OP_LW);
                retired    = 1'b1;
                end_instr  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // run is only honoured at instruction boundaries
        if (end_instr) state_d = run ? FETCH : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retired) count_q <= count_q + CNT_W'(1);
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule
